// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage that owns the PC, reads instruction_memory combinationally and hands registered instructions to decode over valid/ready.
// Ports: clk/rst_n (async active-low); start begins fetching from IDLE;
//   imem_addr/imem_instr form the combinational memory read;
//   instr_out/pc_out/instr_valid/instr_ready form the decode handshake;
//   redirect_valid/redirect_target flush the slot and reload the PC;
//   halted flags the HALTED state; instr_count is a saturating count of transfers.
module fetch_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 9,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
  parameter logic [DATA_WIDTH-1:0] HALT_INSTR = 9'h1FF,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic [DATA_WIDTH-1:0]  imem_instr,
  output logic [DATA_WIDTH-1:0]  instr_out,
  output logic [ADDR_WIDTH-1:0]  pc_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_target,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] instr_count
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d, pc_out_q, pc_out_d;
  logic [DATA_WIDTH-1:0]  instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   xfer, capture;
  assign xfer    = valid_q && instr_ready;
  // a transfer on this edge frees the slot, so capture may refill it in the same cycle
  assign capture = state_q == RUN && !redirect_valid && (!valid_q || instr_ready);
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    valid_d  = xfer ? 1'b0 : valid_q;
    cnt_d    = (xfer && cnt_q != '1) ? cnt_q + COUNT_WIDTH'(1) : cnt_q;
    if (state_q == IDLE) begin
      state_d = start ? RUN : IDLE;
    end else if (redirect_valid) begin
      pc_d    = redirect_target;
      valid_d = 1'b0;
      state_d = RUN;
    end else if (capture) begin
      instr_d  = imem_instr;
      pc_out_d = pc_q;
      valid_d  = 1'b1;
      state_d  = imem_instr == HALT_INSTR ? HALTED : RUN;
      pc_d     = imem_instr == HALT_INSTR ? pc_q : pc_q + ADDR_WIDTH'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pc_q     <= RESET_ADDR;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end
  assign imem_addr   = pc_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_out_q;
  assign instr_valid = valid_q;
  assign halted      = state_q == HALTED;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checking of fetch_unit against a behavioural model.
module tb_fetch_unit;
  localparam int AW = 10, DW = 9, CW = 5, MAXC = 31;
  logic          clk = 0, rst_n = 1, start = 0, instr_ready = 0, redirect_valid = 0;
  logic [AW-1:0] redirect_target = '0, imem_addr, pc_out;
  logic [DW-1:0] imem_instr, instr_out;
  logic          instr_valid, halted;
  logic [CW-1:0] instr_count;
  logic [DW-1:0] mem [1024];
  int n_chk = 0, n_pass = 0;
  fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_ADDR('0), .HALT_INSTR(9'h1FF), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .instr_out(instr_out), .pc_out(pc_out), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target), .halted(halted),
    .instr_count(instr_count));
  assign imem_instr = mem[imem_addr];
  always #5 clk = ~clk;
  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
  endfunction
  // behavioural model: what decode should see, derived from the fetch rules
  bit      m_active, m_halted, m_valid, m_xfer, m_free;
  int      m_pc, m_spc, m_cnt;
  int      m_instr;
  always @(negedge rst_n) begin
    m_active = 0; m_halted = 0; m_valid = 0; m_pc = 0; m_spc = 0; m_instr = 0; m_cnt = 0;
  end
  always @(posedge clk) if (rst_n) begin
    m_xfer = m_valid && instr_ready;
    m_free = !m_valid || instr_ready;
    if (m_xfer && m_cnt < MAXC) m_cnt++;
    if (!m_active) begin
      if (start) m_active = 1;
    end else if (redirect_valid) begin
      m_pc = int'(redirect_target); m_valid = 0; m_halted = 0;
    end else begin
      if (m_xfer) m_valid = 0;
      if (!m_halted && m_free) begin
        m_instr = int'(mem[m_pc]); m_spc = m_pc; m_valid = 1;
        if (m_instr == 'h1FF) m_halted = 1;
        else m_pc = (m_pc + 1) % 1024;
      end
    end
  end
  always @(negedge clk) begin
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    chk("instr_valid", 32'(instr_valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
    if (m_valid) begin
      chk("instr_out", 32'(instr_out), 32'(m_instr));
      chk("pc_out", 32'(pc_out), 32'(m_spc));
    end
  end
  task automatic step();
    @(posedge clk); #2;
  endtask
  task automatic slot(string n, logic [DW-1:0] i, logic [AW-1:0] p);
    chk({n, " valid"}, 32'(instr_valid), 1);
    chk({n, " instr"}, 32'(instr_out), 32'(i));
    chk({n, " pc"}, 32'(pc_out), 32'(p));
  endtask
  task automatic pulse_reset();
    rst_n = 0; #1;
    chk("rst valid", 32'(instr_valid), 0);
    chk("rst halted", 32'(halted), 0);
    chk("rst count", 32'(instr_count), 0);
    chk("rst addr", 32'(imem_addr), 0);
    chk("rst instr", 32'(instr_out), 0);
    chk("rst pc", 32'(pc_out), 0);
    #1 rst_n = 1;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 9'(i) & 9'h0FF;
    mem[0] = 9'h011; mem[1] = 9'h022; mem[2] = 9'h033; mem[3] = 9'h1FF;
    mem[5] = 9'h055; mem[9'h10] = 9'h0AA; mem[9'h11] = 9'h0BB;
    mem[10'h200] = 9'h123; mem[10'h201] = 9'h001; mem[10'h3FF] = 9'h0F0;
    #1 rst_n = 0;
    step(); step();
    pulse_reset();
    // straight-line program ending in HALT
    start = 1; instr_ready = 1; step(); start = 0;
    step(); slot("t1 e1", 9'h011, 0); chk("t1 cnt0", 32'(instr_count), 0);
    step(); slot("t1 e2", 9'h022, 1);
    step(); slot("t1 e3", 9'h033, 2);
    step(); slot("t1 e4", 9'h1FF, 3); chk("t1 halted", 32'(halted), 1); chk("t1 addr", 32'(imem_addr), 3);
    step(); chk("t1 cnt", 32'(instr_count), 4); chk("t1 drained", 32'(instr_valid), 0);
    chk("t1 addr hold", 32'(imem_addr), 3); chk("t1 still halted", 32'(halted), 1);
    pulse_reset();
    // redirect and start while idle: only start leaves IDLE
    redirect_valid = 1; redirect_target = 10'h055; step(); redirect_valid = 0;
    chk("idle redirect addr", 32'(imem_addr), 0); chk("idle redirect valid", 32'(instr_valid), 0);
    step(); chk("idle no fetch", 32'(instr_valid), 0);
    start = 1; step(); start = 0;
    step(); slot("t2 e1", 9'h011, 0);
    step(); slot("t2 e2", 9'h022, 1); instr_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step(); slot("t2 stall", 9'h022, 1); chk("t2 stall addr", 32'(imem_addr), 2);
    end
    instr_ready = 1;
    step(); slot("t2 resume", 9'h033, 2);
    step(); slot("t2 halt", 9'h1FF, 3); chk("t2 cnt", 32'(instr_count), 3);
    // squash an undelivered HALT
    instr_ready = 0; redirect_valid = 1; redirect_target = 10'h010; step(); redirect_valid = 0;
    chk("t4 halted", 32'(halted), 0); chk("t4 flush", 32'(instr_valid), 0);
    chk("t4 addr", 32'(imem_addr), 10'h010); chk("t4 cnt", 32'(instr_count), 3);
    instr_ready = 1;
    step(); slot("t4 e1", 9'h0AA, 10'h010);
    step(); slot("t4 e2", 9'h0BB, 10'h011); chk("t4 cnt2", 32'(instr_count), 4);
    // redirect coinciding with a transfer still counts it
    redirect_valid = 1; redirect_target = 10'd5; step(); redirect_valid = 0; instr_ready = 0;
    chk("t3 cnt xfer", 32'(instr_count), 5);
    step(); slot("t3 held", 9'h055, 5);
    step(); slot("t3 held2", 9'h055, 5);
    redirect_valid = 1; redirect_target = 10'h200; step(); redirect_valid = 0;
    chk("t3 flush", 32'(instr_valid), 0); chk("t3 cnt", 32'(instr_count), 5);
    instr_ready = 1;
    step(); slot("t3 target", 9'h123, 10'h200); chk("t3 cnt2", 32'(instr_count), 5);
    step(); chk("t3 cnt3", 32'(instr_count), 6);
    // PC wrap
    redirect_valid = 1; redirect_target = 10'h3FF; step(); redirect_valid = 0;
    step(); slot("t5 top", 9'h0F0, 10'h3FF);
    step(); slot("t5 wrap", 9'h011, 10'h000);
    // counter saturation
    mem[3] = 9'h044;
    pulse_reset();
    start = 1; step(); start = 0;
    repeat (40) step();
    chk("sat cnt", 32'(instr_count), MAXC);
    // randomized phase
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 11) == 0) ? 9'h1FF : 9'($urandom_range(0, 510));
    for (int c = 0; c < 4000; c++) begin
      step();
      instr_ready     = $urandom_range(0, 9) < 7;
      redirect_valid  = $urandom_range(0, 19) == 0;
      redirect_target = 10'($urandom_range(0, 1023));
      start           = $urandom_range(0, 3) == 0;
      if ($urandom_range(0, 499) == 0) pulse_reset();
    end
    step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
